// File: rtl/div_unit_if.sv
// Operand/result handshake between the execute stage (master) and the divider (slave).
interface div_unit_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// 32-step restoring divider for DIV/DIVU; returns {remainder, quotient} and holds it
// until execute drops start.
//
// state   | meaning
// FREE    | idle, outputs zero, waiting for an unannulled start
// DIVZERO | divisor was zero, zero result presented next edge
// DIVON   | shifting/subtracting, cnt counts completed steps
// DIVEND  | result valid, held until start drops
module div_unit (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_FREE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_DIVON   = 2'd2,
        S_DIVEND  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] r_q, r_d;
    logic [31:0] q_q, q_d;
    logic [31:0] d_q, d_d;
    logic        sd_q, sd_d;
    logic        ss_q, ss_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic        accept;
    logic [31:0] dvd_mag, dvs_mag;
    logic [32:0] p, diff;
    logic [31:0] quo_fix, rem_fix;

    assign accept  = bus.start_i && !bus.annul_i;
    assign dvd_mag = (bus.signed_div_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
    assign dvs_mag = (bus.signed_div_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;

    // Borrow out of the 33-bit subtract means the partial remainder is below the divisor.
    assign p       = {r_q, q_q[31]};
    assign diff    = p - {1'b0, d_q};
    assign quo_fix = (sd_q ^ ss_q) ? (~q_q + 32'd1) : q_q;
    assign rem_fix = sd_q ? (~r_q + 32'd1) : r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FREE;
            cnt_q    <= 6'd0;
            r_q      <= 32'd0;
            q_q      <= 32'd0;
            d_q      <= 32'd0;
            sd_q     <= 1'b0;
            ss_q     <= 1'b0;
            result_q <= 64'd0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            q_q      <= q_d;
            d_q      <= d_d;
            sd_q     <= sd_d;
            ss_q     <= ss_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FREE: begin
                if (accept) begin
                    state_d = (bus.opdata2_i == 32'd0) ? S_DIVZERO : S_DIVON;
                end
            end
            S_DIVZERO: state_d = S_DIVEND;
            S_DIVON: begin
                if (bus.annul_i) begin
                    state_d = S_FREE;
                end else if (cnt_q == 6'd32) begin
                    state_d = S_DIVEND;
                end
            end
            S_DIVEND: begin
                if (!bus.start_i) begin
                    state_d = S_FREE;
                end
            end
            default: state_d = S_FREE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        r_d      = r_q;
        q_d      = q_q;
        d_d      = d_q;
        sd_d     = sd_q;
        ss_d     = ss_q;
        result_d = result_q;
        ready_d  = ready_q;
        case (state_q)
            S_FREE: begin
                result_d = 64'd0;
                ready_d  = 1'b0;
                if (accept) begin
                    sd_d = bus.opdata1_i[31] & bus.signed_div_i;
                    ss_d = bus.opdata2_i[31] & bus.signed_div_i;
                    if (bus.opdata2_i != 32'd0) begin
                        cnt_d = 6'd0;
                        q_d   = dvd_mag;
                        r_d   = 32'd0;
                        d_d   = dvs_mag;
                    end
                end
            end
            S_DIVZERO: begin
                result_d = 64'd0;
                ready_d  = 1'b1;
            end
            S_DIVON: begin
                if (bus.annul_i) begin
                    cnt_d    = 6'd0;
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end else if (cnt_q != 6'd32) begin
                    r_d   = diff[32] ? p[31:0] : diff[31:0];
                    q_d   = {q_q[30:0], ~diff[32]};
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                end
            end
            S_DIVEND: begin
                if (!bus.start_i) begin
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                result_d = 64'd0;
                ready_d  = 1'b0;
            end
        endcase
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: vector table plus random operands, annul, reset and operand-toggle sequences.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_unit_if bus_if ();
    div_unit dut (.clk(clk), .rst(rst), .bus(bus_if));

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    int checks   = 0;
    int failures = 0;
    logic [63:0] sb_q [$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input bit toggle);
        int lat;
        logic [63:0] e;
        bus_if.signed_div_i = sgn;
        bus_if.opdata1_i    = a;
        bus_if.opdata2_i    = b;
        bus_if.start_i      = 1'b1;
        sb_q.push_back(exp);
        lat = -1;
        for (int n = 0; n < 60; n++) begin
            step();
            if (bus_if.ready_o) begin
                lat = n;
                break;
            end
            if (toggle) begin
                bus_if.opdata1_i    = $urandom;
                bus_if.opdata2_i    = $urandom;
                bus_if.signed_div_i = 1'($urandom_range(0, 1));
            end
        end
        e = sb_q.pop_front();
        chk("latency", 64'(lat), (b == 32'd0) ? 64'd1 : 64'd33);
        chk("result", bus_if.result_o, e);
        step();
        chk("hold_ready", 64'(bus_if.ready_o), 64'd1);
        chk("hold_result", bus_if.result_o, e);
        bus_if.start_i = 1'b0;
        step();
        chk("clr_ready", 64'(bus_if.ready_o), 64'd0);
        chk("clr_result", bus_if.result_o, 64'd0);
    endtask

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (!sgn) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic        rs;
        logic [31:0] ra, rb;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD};
        vecs[2]  = '{1'b1, 32'h00000007,   32'hFFFFFFFE,   64'h00000001_FFFFFFFD};
        vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000};
        vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'h00000001,   64'h00000000_FFFFFFFF};
        vecs[5]  = '{1'b1, 32'h12345678,   32'h00000000,   64'h00000000_00000000};
        vecs[6]  = '{1'b0, 32'h12345678,   32'h00000000,   64'h00000000_00000000};
        vecs[7]  = '{1'b1, 32'hFFFFFF9C,   32'h00000007,   64'hFFFFFFFE_FFFFFFF2};
        vecs[8]  = '{1'b1, 32'h00000064,   32'hFFFFFFF9,   64'h00000002_FFFFFFF2};
        vecs[9]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E};
        vecs[10] = '{1'b0, 32'hFFFFFFF9,   32'h00000002,   64'h00000001_7FFFFFFC};
        vecs[11] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000};

        rst                 = 1'b1;
        bus_if.signed_div_i = 1'b0;
        bus_if.opdata1_i    = 32'd0;
        bus_if.opdata2_i    = 32'd0;
        bus_if.start_i      = 1'b0;
        bus_if.annul_i      = 1'b0;
        step();
        step();
        chk("reset_ready", 64'(bus_if.ready_o), 64'd0);
        chk("reset_result", bus_if.result_o, 64'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < NV; i++) begin
            run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
        end

        for (int i = 0; i < 6; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_div(rs, ra, rb, model(rs, ra, rb), 1'b0);
        end

        // Annul at E10: no ready, then a fresh divide completes normally.
        bus_if.signed_div_i = 1'b0;
        bus_if.opdata1_i    = 32'd100;
        bus_if.opdata2_i    = 32'd7;
        bus_if.start_i      = 1'b1;
        for (int i = 0; i < 10; i++) step();
        bus_if.annul_i = 1'b1;
        step();
        chk("annul_ready", 64'(bus_if.ready_o), 64'd0);
        bus_if.annul_i = 1'b0;
        bus_if.start_i = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus_if.ready_o) bad++;
        end
        chk("annul_no_ready", 64'(bad), 64'd0);
        run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);

        // Start while annul is high in FREE must be ignored entirely.
        bus_if.annul_i = 1'b1;
        bus_if.start_i = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus_if.ready_o) bad++;
        end
        bus_if.annul_i = 1'b0;
        bus_if.start_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus_if.ready_o) bad++;
        end
        chk("annul_free_ignored", 64'(bad), 64'd0);

        // Reset at E20 of a divide.
        bus_if.opdata1_i = 32'd100;
        bus_if.opdata2_i = 32'd7;
        bus_if.start_i   = 1'b1;
        for (int i = 0; i < 20; i++) step();
        rst = 1'b1;
        step();
        chk("rst_mid_ready", 64'(bus_if.ready_o), 64'd0);
        chk("rst_mid_result", bus_if.result_o, 64'd0);
        rst = 1'b0;
        bus_if.start_i = 1'b0;
        step();
        run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);

        // Reset while a result is being held.
        bus_if.signed_div_i = 1'b1;
        bus_if.opdata1_i    = 32'h00000007;
        bus_if.opdata2_i    = 32'hFFFFFFFE;
        bus_if.start_i      = 1'b1;
        for (int i = 0; i < 34; i++) step();
        chk("pre_rst_result", bus_if.result_o, 64'h00000001_FFFFFFFD);
        rst = 1'b1;
        step();
        chk("rst_end_ready", 64'(bus_if.ready_o), 64'd0);
        chk("rst_end_result", bus_if.result_o, 64'd0);
        rst = 1'b0;
        bus_if.start_i = 1'b0;
        step();

        // Operands toggled throughout DIVON must not disturb the result.
        run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b1);
        run_div(1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit signed/unsigned integer divider serving the execute stage's DIV/DIVU instructions. Execute issues an operand pair with a start request. The unit runs a 32-step restoring division and returns a 64-bit {remainder, quotient} result with a ready flag. Execute stalls the pipeline on this flag and then writes the result into HI (remainder) and LO (quotient) through its normal HI/LO write path.

## Interface
Parameters: none (fixed 32-bit datapath).

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- opdata1_i  in  32  dividend; sampled with start
- opdata2_i  in  32  divisor; sampled with start
- start_i  in  1  request; held high by execute until it consumes the result
- annul_i  in  1  abort (branch/flush); forces return to FREE
- result_o  out  64  {remainder[31:0], quotient[31:0]}; registered
- ready_o  out  1  result valid; registered

## Operation
- States: FREE, DIVZERO, DIVON, DIVEND. Internal registers: `cnt[5:0]`, `R[31:0]`, `Q[31:0]`, `D[31:0]`, latched sign bits `sd`, `ss`.
- Reset: state FREE, `cnt` = 0, `result_o` = 0, `ready_o` = 0. Reset has priority over every other input in every state.
- **FREE**
  - `ready_o` = 0 and `result_o` = 0.
  - If `start_i` = 1 and `annul_i` = 0:
    - Divisor = 0: go to DIVZERO.
    - Otherwise: go to DIVON with `cnt` = 0, `Q` = |dividend|, `R` = 0, `D` = |divisor|.
    - Magnitudes are taken only when `signed_div_i` = 1; otherwise operands are used raw.
    - `sd` = dividend sign AND `signed_div_i`; `ss` = divisor sign AND `signed_div_i`.
  - If `annul_i` = 1, the start is ignored.
- **DIVZERO**: next edge goes to DIVEND with `result_o` = 0 and `ready_o` = 1.
- **DIVON** (if `annul_i` = 1 at an edge, go to FREE with `cnt` = 0 and outputs 0; otherwise):
  - While `cnt` < 32, one step per edge:
    - `P` = {`R`, `Q[31]`} (33 bits).
    - If `P` >= `D`: `R` = `P` − `D`, `Q` = {`Q[30:0]`, 1}.
    - Else: `R` = `P[31:0]`, `Q` = {`Q[30:0]`, 0}.
    - `cnt` += 1.
  - When `cnt` = 32, apply sign fix-up and go to DIVEND:
    - Quotient is negated if `sd` XOR `ss`.
    - Remainder is negated if `sd`.
    - `result_o` = {rem, quo}, `ready_o` = 1.
- **DIVEND**
  - While `start_i` = 1, hold `result_o` and `ready_o`.
  - When `start_i` = 0, go to FREE and clear `result_o` and `ready_o` to 0.
  - `annul_i` has no effect in this state.
- Arithmetic:
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
  - Two's-complement negation wraps, so 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0.
  - Remainder takes the sign of the dividend (MIPS semantics).
- Operand changes after the start edge are ignored.

## Timing
- Call the edge sampling the start E0. Normal divide:
  - E1–E32 perform the 32 steps.
  - E33 performs the fix-up.
  - `ready_o` is high in the cycle after E33, which is 34 cycles after `start_i` is first seen.
- Divide by zero: `ready_o` is high after E1.
- Result consumption: `start_i` low at edge En clears `ready_o` after En. A new start is accepted no earlier than En+1, from FREE.
- Annul at any DIVON edge: `ready_o` never rises for that operation.
- Back-to-back divides have a minimum 1-cycle FREE gap.

## Test plan
- Unsigned 100 / 7:
  - `result_o` = 0x00000002_0000000E.
  - `ready_o` rises exactly 34 cycles after start.
  - Result holds while start is high and clears the cycle after start drops.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002) → 0xFFFFFFFF_FFFFFFFD. Signed 7 / −2 → 0x00000001_FFFFFFFD.
- Signed 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000. Unsigned 0xFFFFFFFF / 1 → 0x00000000_FFFFFFFF.
- Divisor 0 (signed and unsigned): `ready_o` high after 2 edges, `result_o` = 0.
- `annul_i` pulsed at edge E10:
  - State returns to FREE and `ready_o` stays 0.
  - A following start of 100 / 7 completes normally with the correct result.
  - A start with `annul_i` = 1 in FREE is ignored.
- Reset mid-operation:
  - `rst` at edge E20 clears `ready_o`, `result_o` and the state.
  - Operand changes during DIVON do not alter the result (verify with 100 / 7 while toggling inputs).
